// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared types and constants for the rv32i round-robin memory arbiter.
package rv32i_mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  localparam int STAT_W = 32;

  // Port index width; a single-port arbiter still needs one bit.
  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Requester-side bundle: per-port request/accept strobes plus shared read response.
interface rv32i_mem_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);

  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0]        req_wr_ena;
  logic [NUM_PORTS*DATA_W-1:0] req_wr_data;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]           rsp_rd_data;

  modport master (
    output req_valid, req_addr, req_wr_ena, req_wr_data,
    input  req_ready, rsp_valid, rsp_rd_data
  );

  modport slave (
    input  req_valid, req_addr, req_wr_ena, req_wr_data,
    output req_ready, rsp_valid, rsp_rd_data
  );

endinterface

// File: rtl/rv32i_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after i_ptr wins.
module rr_picker
  import rv32i_mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = ptrWidth(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [PTR_W-1:0]     o_winner,
  output logic                 o_any
);

  logic [PTR_W-1:0] w_idx;

  // With no requester the winner falls back to ptr+1 so the memory bus stays stable.
  always_comb begin
    o_grant  = '0;
    o_any    = 1'b0;
    w_idx    = '0;
    o_winner = PTR_W'((int'(i_ptr) + 1) % NUM_PORTS);
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + 1 + k) % NUM_PORTS);
      if (!o_any && i_req[w_idx]) begin
        o_any    = 1'b1;
        o_winner = w_idx;
      end
    end
    if (o_any) o_grant[o_winner] = 1'b1;
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// N-port round-robin arbiter in front of a single-ported RAM with configurable read latency.
// Optional per-port grant/stall counters are built when MEM_ARB_STATS_EN is defined.
module rv32i_mem_arbiter
  import rv32i_mem_arb_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  rv32i_mem_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr_ena,
  output logic [DATA_W-1:0] o_mem_wr_data,
  input  logic [DATA_W-1:0] i_mem_rd_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*STAT_W-1:0] o_stat_grants,
  output logic [NUM_PORTS*STAT_W-1:0] o_stat_stalls
`endif
);

  localparam int PTR_W = ptrWidth(NUM_PORTS);
  localparam int CNT_W = ($clog2(READ_LATENCY + 1) < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = (READ_LATENCY > 0) ? CNT_W'(READ_LATENCY - 1) : '0;

  arb_state_t             r_state;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       r_owner;
  logic [CNT_W-1:0]       r_cnt;

  logic [NUM_PORTS-1:0]   w_grant;
  logic [PTR_W-1:0]       w_winner;
  logic                   w_any;
  logic                   w_accept;
  logic                   w_isWrite;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .i_req    (bus.req_valid),
    .i_ptr    (r_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_accept      = rst && (r_state == IDLE) && w_any;
  assign w_isWrite     = bus.req_wr_ena[w_winner];
  assign o_mem_addr    = bus.req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
  assign o_mem_wr_data = bus.req_wr_data[int'(w_winner)*DATA_W +: DATA_W];

  // Zero-latency reads answer in the accept cycle; otherwise the owner is answered from WAIT.
  always_comb begin
    bus.req_ready   = '0;
    bus.rsp_valid   = '0;
    bus.rsp_rd_data = '0;
    o_mem_wr_ena    = 1'b0;
    if (w_accept) begin
      bus.req_ready = w_grant;
      o_mem_wr_ena  = w_isWrite;
      if (!w_isWrite && (READ_LATENCY == 0)) bus.rsp_valid = w_grant;
    end
    if (rst && (r_state == WAIT) && (r_cnt == '0)) bus.rsp_valid[r_owner] = 1'b1;
    if (|bus.rsp_valid) bus.rsp_rd_data = i_mem_rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= PTR_W'(NUM_PORTS - 1);
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ptr <= w_winner;
            if (!w_isWrite && (READ_LATENCY > 0)) begin
              r_owner <= w_winner;
              r_cnt   <= CNT_LOAD;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] r_grantCnt [NUM_PORTS];
  logic [STAT_W-1:0] r_stallCnt [NUM_PORTS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!rst) begin
        r_grantCnt[i] <= '0;
        r_stallCnt[i] <= '0;
      end else begin
        if (bus.req_valid[i] && bus.req_ready[i])  r_grantCnt[i] <= r_grantCnt[i] + STAT_W'(1);
        if (bus.req_valid[i] && !bus.req_ready[i]) r_stallCnt[i] <= r_stallCnt[i] + STAT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
    assign o_stat_grants[g*STAT_W +: STAT_W] = r_grantCnt[g];
    assign o_stat_stalls[g*STAT_W +: STAT_W] = r_stallCnt[g];
  end
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: four instances cover latency 0/2/3 and 1/2/3 ports.
module tb_rv32i_mem_arbiter;
  import rv32i_mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) ifL0 ();
  rv32i_mem_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32)) ifL2 ();
  rv32i_mem_arbiter_if #(.NUM_PORTS(1), .ADDR_W(32), .DATA_W(32)) ifL3 ();
  rv32i_mem_arbiter_if #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) ifN3 ();

  logic [31:0] memAddrL0, memWdL0, memRdL0;
  logic [31:0] memAddrL2, memWdL2, memRdL2;
  logic [31:0] memAddrL3, memWdL3, memRdL3;
  logic [31:0] memAddrN3, memWdN3, memRdN3;
  logic        memWeL0, memWeL2, memWeL3, memWeN3;
`ifdef MEM_ARB_STATS_EN
  logic [2*STAT_W-1:0] statGrL0, statStL0, statGrL2, statStL2;
  logic [STAT_W-1:0]   statGrL3, statStL3;
  logic [3*STAT_W-1:0] statGrN3, statStN3;
`endif

  rv32i_mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(0)) uL0 (
    .clk(clk), .rst(rst), .bus(ifL0.slave),
    .o_mem_addr(memAddrL0), .o_mem_wr_ena(memWeL0), .o_mem_wr_data(memWdL0), .i_mem_rd_data(memRdL0)
`ifdef MEM_ARB_STATS_EN
    , .o_stat_grants(statGrL0), .o_stat_stalls(statStL0)
`endif
  );

  rv32i_mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(2)) uL2 (
    .clk(clk), .rst(rst), .bus(ifL2.slave),
    .o_mem_addr(memAddrL2), .o_mem_wr_ena(memWeL2), .o_mem_wr_data(memWdL2), .i_mem_rd_data(memRdL2)
`ifdef MEM_ARB_STATS_EN
    , .o_stat_grants(statGrL2), .o_stat_stalls(statStL2)
`endif
  );

  rv32i_mem_arbiter #(.NUM_PORTS(1), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) uL3 (
    .clk(clk), .rst(rst), .bus(ifL3.slave),
    .o_mem_addr(memAddrL3), .o_mem_wr_ena(memWeL3), .o_mem_wr_data(memWdL3), .i_mem_rd_data(memRdL3)
`ifdef MEM_ARB_STATS_EN
    , .o_stat_grants(statGrL3), .o_stat_stalls(statStL3)
`endif
  );

  rv32i_mem_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(0)) uN3 (
    .clk(clk), .rst(rst), .bus(ifN3.slave),
    .o_mem_addr(memAddrN3), .o_mem_wr_ena(memWeN3), .o_mem_wr_data(memWdN3), .i_mem_rd_data(memRdN3)
`ifdef MEM_ARB_STATS_EN
    , .o_stat_grants(statGrN3), .o_stat_stalls(statStN3)
`endif
  );

  // Word-addressed memory model; the latency-2/3 instances see it through read pipelines.
  logic [31:0] mem [64];
  logic [31:0] pipeL2 [2];
  logic [31:0] pipeL3 [3];
  logic        memReady = 1'b0;

  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[2]   <= 32'h11110008;
      mem[4]   <= 32'hAAAA0010;
      mem[8]   <= 32'hBBBB0020;
      mem[12]  <= 32'hCAFE0030;
      mem[16]  <= 32'hDEADBEEF;
      memReady <= 1'b1;
    end else if (memWeL0) begin
      mem[memAddrL0[7:2]] <= memWdL0;
    end
    pipeL2[0] <= mem[memAddrL2[7:2]];
    pipeL2[1] <= pipeL2[0];
    pipeL3[0] <= mem[memAddrL3[7:2]];
    pipeL3[1] <= pipeL3[0];
    pipeL3[2] <= pipeL3[1];
  end

  assign memRdL0 = mem[memAddrL0[7:2]];
  assign memRdL2 = pipeL2[1];
  assign memRdL3 = pipeL3[2];
  assign memRdN3 = mem[memAddrN3[7:2]];

  // Inputs change on the falling edge; outputs are sampled 2ns later, well before the rising edge.
  task automatic applyStimulus();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic [1:0]  expRr  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] expRd  [4] = '{32'hAAAA0010, 32'hBBBB0020, 32'hAAAA0010, 32'hBBBB0020};
  logic [2:0]  expRot [3] = '{3'b001, 3'b010, 3'b100};
  logic [31:0] expRot3 [3] = '{32'hAAAA0010, 32'hBBBB0020, 32'hDEADBEEF};

  initial begin
    rst = 1'b0;
    ifL0.req_valid = 2'b11; ifL0.req_wr_ena = '0; ifL0.req_addr = '0; ifL0.req_wr_data = '0;
    ifL2.req_valid = 2'b11; ifL2.req_wr_ena = '0; ifL2.req_addr = '0; ifL2.req_wr_data = '0;
    ifL3.req_valid = 1'b1;  ifL3.req_wr_ena = '0; ifL3.req_addr = '0; ifL3.req_wr_data = '0;
    ifN3.req_valid = 3'b111; ifN3.req_wr_ena = '0; ifN3.req_addr = '0; ifN3.req_wr_data = '0;

    $display("[TB] reset with all requests raised");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(); #2;
      checkOutput("reset_ctrl",
        {ifL0.req_ready, ifL0.rsp_valid, memWeL0, ifL2.req_ready, ifL2.rsp_valid, memWeL2,
         ifL3.req_ready, ifL3.rsp_valid, memWeL3, ifN3.req_ready, ifN3.rsp_valid, memWeN3}, '0);
      checkOutput("reset_rdata", {ifL0.rsp_rd_data, ifN3.rsp_rd_data}, '0);
    end

    $display("[TB] latency 0, two ports reading continuously");
    applyStimulus();
    rst = 1'b1;
    ifL2.req_valid = '0; ifL3.req_valid = '0; ifN3.req_valid = '0;
    ifL0.req_addr  = {32'h20, 32'h10};
    ifL0.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) applyStimulus();
      #2;
      checkOutput("rr_ready", ifL0.req_ready, expRr[k]);
      checkOutput("rr_rsp_valid", ifL0.rsp_valid, expRr[k]);
      checkOutput("rr_rd_data", ifL0.rsp_rd_data, expRd[k]);
    end

    $display("[TB] write then read of the same word");
    applyStimulus();
    ifL0.req_addr    = {32'h8, 32'h8};
    ifL0.req_wr_ena  = 2'b01;
    ifL0.req_wr_data = {32'h0, 32'h55};
    ifL0.req_valid   = 2'b11;
    #2;
    checkOutput("wr_ready", ifL0.req_ready, 2'b01);
    checkOutput("wr_ena", memWeL0, 1'b1);
    checkOutput("wr_addr_data", {memAddrL0, memWdL0}, {32'h8, 32'h55});
    checkOutput("wr_no_rsp", ifL0.rsp_valid, 2'b00);
    applyStimulus();
    ifL0.req_valid  = 2'b10;
    ifL0.req_wr_ena = 2'b00;
    #2;
    checkOutput("rd_after_wr_ready", ifL0.req_ready, 2'b10);
    checkOutput("rd_after_wr_rsp", ifL0.rsp_valid, 2'b10);
    checkOutput("rd_after_wr_data", ifL0.rsp_rd_data, 32'h55);
    checkOutput("rd_after_wr_we", memWeL0, 1'b0);

    $display("[TB] idle cycle keeps the pointer");
    applyStimulus();
    ifL0.req_valid = 2'b00;
    ifL0.req_addr  = {32'h20, 32'h10};
    #2;
    checkOutput("idle_ctrl", {ifL0.req_ready, ifL0.rsp_valid, memWeL0}, 5'b0);
    checkOutput("idle_addr", memAddrL0, 32'h10);
    checkOutput("idle_rdata", ifL0.rsp_rd_data, 32'h0);
    applyStimulus();
    ifL0.req_valid = 2'b11;
    #2;
    checkOutput("after_idle_ready", ifL0.req_ready, 2'b01);

    $display("[TB] latency 2 read from port 1");
    applyStimulus();
    ifL0.req_valid = 2'b00;
    ifL2.req_addr  = {32'h40, 32'h10};
    ifL2.req_valid = 2'b10;
    #2;
    checkOutput("l2_accept_ready", ifL2.req_ready, 2'b10);
    checkOutput("l2_accept_rsp", ifL2.rsp_valid, 2'b00);
    checkOutput("l2_accept_addr", memAddrL2, 32'h40);
    applyStimulus();
    ifL2.req_valid = 2'b01;
    #2;
    checkOutput("l2_wait1", {ifL2.req_ready, ifL2.rsp_valid, memWeL2}, 5'b0);
    applyStimulus();
    #2;
    checkOutput("l2_wait2_ready", ifL2.req_ready, 2'b00);
    checkOutput("l2_rsp_valid", ifL2.rsp_valid, 2'b10);
    checkOutput("l2_rsp_data", ifL2.rsp_rd_data, 32'hDEADBEEF);
    applyStimulus();
    #2;
    checkOutput("l2_next_ready", ifL2.req_ready, 2'b01);
    checkOutput("l2_next_rsp", ifL2.rsp_valid, 2'b00);
    applyStimulus();
    ifL2.req_valid = 2'b00;
    #2;
    checkOutput("l2_next_wait", {ifL2.req_ready, ifL2.rsp_valid}, 4'b0);
    applyStimulus();
    #2;
    checkOutput("l2_next_rsp_valid", ifL2.rsp_valid, 2'b01);
    checkOutput("l2_next_rsp_data", ifL2.rsp_rd_data, 32'hAAAA0010);

    $display("[TB] latency 3 single port, reset during wait");
    applyStimulus();
    ifL3.req_addr  = 32'h30;
    ifL3.req_valid = 1'b1;
    #2;
    checkOutput("l3_accept_ready", ifL3.req_ready, 1'b1);
    checkOutput("l3_accept_addr", memAddrL3, 32'h30);
    applyStimulus();
    ifL3.req_valid = 1'b0;
    rst = 1'b0;
    #2;
    checkOutput("l3_in_reset", {ifL3.req_ready, ifL3.rsp_valid}, 2'b0);
    applyStimulus();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) applyStimulus();
      #2;
      checkOutput("l3_aborted_rsp", ifL3.rsp_valid, 1'b0);
      checkOutput("l3_aborted_data", ifL3.rsp_rd_data, 32'h0);
    end
    applyStimulus();
    ifL3.req_valid = 1'b1;
    #2;
    checkOutput("l3_reissue_ready", ifL3.req_ready, 1'b1);
    applyStimulus();
    ifL3.req_valid = 1'b0;
    #2;
    checkOutput("l3_wait_a", {ifL3.req_ready, ifL3.rsp_valid}, 2'b0);
    applyStimulus();
    #2;
    checkOutput("l3_wait_b", {ifL3.req_ready, ifL3.rsp_valid}, 2'b0);
    applyStimulus();
    #2;
    checkOutput("l3_rsp_valid", ifL3.rsp_valid, 1'b1);
    checkOutput("l3_rsp_data", ifL3.rsp_rd_data, 32'hCAFE0030);

    $display("[TB] three ports, all valid for nine cycles");
    applyStimulus();
    ifN3.req_addr  = {32'h40, 32'h20, 32'h10};
    ifN3.req_valid = 3'b111;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) applyStimulus();
      #2;
      checkOutput("rot_ready", ifN3.req_ready, expRot[k % 3]);
      if (k < 3) checkOutput("rot_data", ifN3.rsp_rd_data, expRot3[k]);
    end
    applyStimulus();
    ifN3.req_valid = 3'b000;
    #2;
    checkOutput("rot_released", ifN3.req_ready, 3'b000);
`ifdef MEM_ARB_STATS_EN
    checkOutput("stat_grants", statGrN3, {32'd3, 32'd3, 32'd3});
    checkOutput("stat_stalls", statStN3, {32'd6, 32'd6, 32'd6});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
